// File: rtl/csa_resolve_serial_if.sv
// Handshake and data bundle for the carry-save resolver.
// The slave side is the resolver. The master side drives operands and
// consumes results.
interface csa_resolve_serial_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             busy;

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_resolve_serial.sv
// Serial carry-propagate resolver for a carry-save (sum, carry) pair.
// It resolves CHUNK bits per clock and keeps a ripple carry between chunks.
// The result is WIDTH+1 bits wide, and its MSB is the final carry-out.
module csa_resolve_serial #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    csa_resolve_serial_if.slave bus
);
    localparam int NCHUNK  = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int KW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Bit position inside the last chunk's sum that carries weight WIDTH.
    localparam int LASTPOS = WIDTH - (NCHUNK - 1) * CHUNK;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] carry_vec_reg;
    logic             cy_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH:0]   result_reg;
    logic [WIDTH:0]   result_next;

    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CHUNK:0]   csum;
    logic             last_chunk;

    // Split the latched operands into chunks. A partial top chunk is zero-extended.
    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_split
            if ((gi + 1) * CHUNK <= WIDTH) begin : g_full
                assign a_chunks[gi] = sum_reg[gi*CHUNK +: CHUNK];
                assign b_chunks[gi] = carry_vec_reg[gi*CHUNK +: CHUNK];
            end else begin : g_part
                assign a_chunks[gi] = CHUNK'(sum_reg[WIDTH-1:gi*CHUNK]);
                assign b_chunks[gi] = CHUNK'(carry_vec_reg[WIDTH-1:gi*CHUNK]);
            end
        end
    endgenerate

    assign last_chunk = (k_reg == KW'(NCHUNK - 1));
    assign csum       = {1'b0, a_chunks[k_reg]} + {1'b0, b_chunks[k_reg]}
                      + {{CHUNK{1'b0}}, cy_reg};

    // Each result bit is updated only while its own chunk is being added.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_res
            assign result_next[gi] = (state_reg == ADD && k_reg == KW'(gi / CHUNK))
                                   ? csum[gi % CHUNK] : result_reg[gi];
        end
    endgenerate
    assign result_next[WIDTH] = (state_reg == ADD && last_chunk)
                              ? csum[LASTPOS] : result_reg[WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_next = ADD;
            end
            ADD: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then ripple one chunk per ADD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            carry_vec_reg <= '0;
            cy_reg        <= 1'b0;
            k_reg         <= '0;
            result_reg    <= '0;
        end else begin
            result_reg <= result_next;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        sum_reg       <= bus.sum_in;
                        carry_vec_reg <= bus.carry_in;
                        cy_reg        <= 1'b0;
                        k_reg         <= '0;
                    end
                end
                ADD: begin
                    cy_reg <= csum[CHUNK];
                    if (!last_chunk) k_reg <= k_reg + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
endmodule

// File: tb/tb_csa_resolve_serial.sv
// Directed bench for csa_resolve_serial.
// It uses a 24-bit/8-bit instance, plus a 20-bit/8-bit instance for the partial top chunk.
module tb_csa_resolve_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    csa_resolve_serial_if #(.WIDTH(24)) bus24();
    csa_resolve_serial_if #(.WIDTH(20)) bus20();

    csa_resolve_serial #(.WIDTH(24), .CHUNK(8)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .bus(bus24)
    );
    csa_resolve_serial #(.WIDTH(20), .CHUNK(8)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .bus(bus20)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation on the 24-bit instance and checks latency and result.
    // The output is held for 'stall' cycles before the result is taken.
    task automatic run24(input logic [23:0] s, input logic [23:0] c,
                         input logic [24:0] exp, input int stall, input string tag);
        int lat;
        @(negedge clk);
        bus24.in_valid  = 1'b1;
        bus24.sum_in    = s;
        bus24.carry_in  = c;
        bus24.out_ready = 1'b0;
        chk({tag, " in_ready"}, 64'(bus24.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus24.in_valid = 1'b0;
        bus24.sum_in   = 24'($urandom);
        bus24.carry_in = 24'($urandom);
        lat = 0;
        while (!bus24.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd3);
        chk({tag, " result"}, 64'(bus24.result), 64'(exp));
        repeat (stall) @(negedge clk);
        chk({tag, " held"}, 64'({bus24.out_valid, bus24.result}), 64'({1'b1, exp}));
        bus24.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus24.out_ready = 1'b0;
        chk({tag, " out_valid_fall"}, 64'(bus24.out_valid), 64'd0);
    endtask

    initial begin
        int gap;
        int lat;
        logic [22:0] a, b, cc;
        logic [23:0] s_v, c_v;
        logic [24:0] exp_v;

        bus24.in_valid = 1'b0; bus24.sum_in = '0; bus24.carry_in = '0; bus24.out_ready = 1'b0;
        bus20.in_valid = 1'b0; bus20.sum_in = '0; bus20.carry_in = '0; bus20.out_ready = 1'b0;

        // Check the outputs while reset is held.
        repeat (3) @(negedge clk);
        chk("reset in_ready",  64'(bus24.in_ready),  64'd1);
        chk("reset out_valid", 64'(bus24.out_valid), 64'd0);
        chk("reset busy",      64'(bus24.busy),      64'd0);
        chk("reset result",    64'(bus24.result),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry ripples across both chunk boundaries.
        run24(24'hFFFFFF, 24'h000001, 25'h1000000, 0, "ripple");
        run24(24'h000000, 24'h000000, 25'h0000000, 1, "zero");
        run24(24'hFFFFFF, 24'hFFFFFE, 25'h1FFFFFD, 2, "max");

        // Back-to-back operations with out_ready held high: accept spacing is 5 cycles.
        @(negedge clk);
        bus24.out_ready = 1'b1;
        bus24.in_valid  = 1'b1;
        bus24.sum_in    = 24'h0000FF;
        bus24.carry_in  = 24'h000001;
        chk("b2b first in_ready", 64'(bus24.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus24.sum_in   = 24'h00FF00;
        bus24.carry_in = 24'h000100;
        gap = 1;
        while (!bus24.in_ready && gap < 20) begin
            if (bus24.out_valid) chk("b2b first result", 64'(bus24.result), 64'h0000100);
            @(negedge clk);
            gap++;
        end
        chk("b2b accept spacing", 64'(gap), 64'd5);
        @(posedge clk);
        @(negedge clk);
        bus24.in_valid = 1'b0;
        lat = 0;
        while (!bus24.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b second latency", 64'(lat), 64'd3);
        chk("b2b second result",  64'(bus24.result), 64'h0010000);
        @(posedge clk);
        @(negedge clk);
        bus24.out_ready = 1'b0;
        chk("b2b idle", 64'({bus24.out_valid, bus24.in_ready}), 64'b01);

        // Backpressure: result held stable and in_valid ignored while out_ready stays low.
        bus24.in_valid = 1'b1;
        bus24.sum_in   = 24'h123456;
        bus24.carry_in = 24'h000000;
        @(posedge clk);
        @(negedge clk);
        bus24.in_valid = 1'b0;
        lat = 0;
        while (!bus24.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", 64'(lat), 64'd3);
        for (int i = 0; i < 6; i++) begin
            bus24.in_valid = i[0];
            bus24.sum_in   = 24'hFFFFFF;
            bus24.carry_in = 24'hFFFFFF;
            @(negedge clk);
            chk("bp out_valid", 64'(bus24.out_valid), 64'd1);
            chk("bp result",    64'(bus24.result),    64'h0123456);
            chk("bp in_ready",  64'(bus24.in_ready),  64'd0);
        end
        bus24.in_valid  = 1'b0;
        bus24.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus24.out_ready = 1'b0;
        chk("bp release", 64'({bus24.out_valid, bus24.in_ready}), 64'b01);
        repeat (4) @(negedge clk);
        chk("bp no phantom op", 64'({bus24.busy, bus24.out_valid}), 64'b00);

        // Reset asserted after one ADD cycle abandons the operation.
        bus24.in_valid = 1'b1;
        bus24.sum_in   = 24'hAAAAAA;
        bus24.carry_in = 24'h555556;
        @(posedge clk);
        @(negedge clk);
        bus24.in_valid = 1'b0;
        chk("rst busy before", 64'(bus24.busy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(bus24.out_valid), 64'd0);
        chk("rst busy",      64'(bus24.busy),      64'd0);
        chk("rst result",    64'(bus24.result),    64'd0);
        chk("rst in_ready",  64'(bus24.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst no out_valid", 64'(bus24.out_valid), 64'd0);
        run24(24'h000002, 24'h000003, 25'h0000005, 0, "after_rst");

        // Partial top chunk on the 20-bit instance.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus20.in_valid  = 1'b1;
            bus20.sum_in    = (t == 0) ? 20'hFFFFF : 20'hABCDE;
            bus20.carry_in  = (t == 0) ? 20'h00001 : 20'h12345;
            bus20.out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            bus20.in_valid = 1'b0;
            lat = 0;
            while (!bus20.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("w20 latency", 64'(lat), 64'd3);
            chk("w20 result", 64'(bus20.result), (t == 0) ? 64'h100000 : 64'h0BE023);
            bus20.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus20.out_ready = 1'b0;
            chk("w20 out_valid_fall", 64'(bus20.out_valid), 64'd0);
        end

        // Random triples are passed through a 3:2 compressor model, with random output stalls.
        for (int n = 0; n < 1000; n++) begin
            a     = 23'($urandom);
            b     = 23'($urandom);
            cc    = 23'($urandom);
            s_v   = {1'b0, a ^ b ^ cc};
            c_v   = {(a & b) | (a & cc) | (b & cc), 1'b0};
            exp_v = 25'(a) + 25'(b) + 25'(cc);
            run24(s_v, c_v, exp_v, int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csa_resolve_serial.md
Name: csa_resolve_serial

Overview:
- Converts a carry-save pair (sum vector, carry vector), as produced by the team's 3:2 CSA compressors, back into a plain binary result.
- Runs a chunked, multi-cycle carry-propagate addition: CHUNK bits per clock, ripple carry held in a register between chunks.
- Sits at the output end of a CSA reduction tree, in front of any consumer that needs a non-redundant value.
- Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 24, bit width of both sum_in and carry_in; both vectors are weight-aligned, and carry_in LSB already holds the zero shift-in.
- CHUNK, 8, bits resolved per clock cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, derived = ceil(WIDTH/CHUNK), number of ADD cycles per operation; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair.
- sum_in  input  WIDTH  CSA sum vector.
- carry_in  input  WIDTH  CSA carry vector, same weights as sum_in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH+1  sum_in + carry_in; MSB is the final carry-out.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, chunk index=0, carry register=0, operand registers=0.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch sum_in and carry_in, clear the carry register, set chunk index=0, go to ADD.
  - Without in_valid: stay in IDLE.
- ADD:
  - in_ready=0; in_valid and operand changes are ignored.
  - Each cycle: add chunk k of both latched vectors plus the carry register.
  - Write the CHUNK-bit sum into result bits [k*CHUNK +: CHUNK]; store the carry-out in the carry register.
  - Increment k.
  - On the cycle k = NCHUNK-1: write the final carry-out to result[WIDTH] (the MSB) and go to DONE.
  - Partial last chunk (WIDTH not a multiple of CHUNK): operand bits above WIDTH are treated as 0. The carry out of bit WIDTH-1 lands in result[WIDTH]. No result bits beyond WIDTH exist.
- DONE:
  - out_valid=1. result and out_valid are held stable until out_ready.
  - On out_valid && out_ready: out_valid falls next cycle and the state returns to IDLE.
  - No same-cycle handoff: in_ready stays 0 in DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
- Minimum accept-to-accept spacing: NCHUNK+2 cycles when out_ready is held high.
- result bits not yet written in ADD keep their old values.
  - Consumers sample only while out_valid=1.
  - Verification checks result only while out_valid=1.
- Arithmetic:
  - result = sum_in + carry_in, unsigned, WIDTH+1 bits; overflow is impossible.
  - For CSA inputs from A, B, C, result equals A+B+C, provided that sum is representable in WIDTH+1 bits.
- rst_n asserted mid-ADD or mid-DONE: the operation is abandoned, all state and outputs return to reset values immediately, and no out_valid is produced for it.
- busy = (state != IDLE).

Test Plan:
- WIDTH=24, CHUNK=8: sum_in=0xFFFFFF, carry_in=0x000001 -> out_valid 3 cycles after accept; result=0x1000000; carry crosses both chunk boundaries.
- sum_in=0x0000FF, carry_in=0x000001 -> result=0x0000100. Back-to-back operands with out_ready=1: second accept occurs exactly 5 cycles after the first.
- Backpressure: after result 0x123456+0x000000, hold out_ready=0 for 6 cycles -> out_valid=1 and result=0x0123456 stable throughout. Toggle in_valid during those cycles -> ignored, in_ready=0.
- Reset mid-operation: accept 0xAAAAAA+0x555556, pull rst_n low after 1 ADD cycle -> immediately out_valid=0, busy=0, result=0. The next operation 0x000002+0x000003 yields 0x0000005.
- Partial chunk, WIDTH=20, CHUNK=8 (NCHUNK=3): sum_in=0xFFFFF, carry_in=0x00001 -> result=0x100000 after 3 cycles.
- Random: 1000 triples A, B, C pushed through a CSA reference model -> result == A+B+C every time, with random out_ready stalls.
